led_dimmer_array: RTL and testbench



---
 rtl/led_dimmer_array.sv | 76 +++++++
 tb/tb_led_dimmer_array.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_dimmer_array.sv
// led_dimmer_array: multi-channel PWM LED dimmer with fixed, sawtooth and breathe modes
module led_dimmer_array #(
  parameter int NLED     = 4,
  parameter int PWM_BITS = 8,
  parameter int AW       = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wr,
  input  logic [AW-1:0]   i_addr,
  input  logic [31:0]     i_data,
  output logic [NLED-1:0] o_led,
  output logic            o_frame
);
  typedef enum logic [1:0] {OFF, FIXED, SAW, BREATHE} mode_e;
  typedef enum logic {UP, DOWN} dir_e;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [PWM_BITS-1:0] ctr_q;
  logic                frame_q;
  logic [NLED-1:0]     led_q, led_d;
  logic                frame_end;
  logic                unused_data;
  assign frame_end   = ctr_q == MAX;
  assign unused_data = ^i_data[7:2];
  assign o_led       = led_q;
  assign o_frame     = frame_q;
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      ctr_q   <= '0;
      frame_q <= 1'b0;
      led_q   <= '0;
    end else begin
      ctr_q   <= ctr_q + PWM_BITS'(1);
      frame_q <= frame_end;
      led_q   <= led_d;
    end
  for (genvar i = 0; i < NLED; i++) begin : g_ch
    mode_e               mode_q, mode_d;
    dir_e                dir_q, dir_d, sdir;
    logic [PWM_BITS-1:0] lvl_q, lvl_d, up, dn, stp;
    logic [15:0]         ivl_q, ivl_d, fc_q, fc_d;
    logic                hit, ramp, take;
    assign led_d[i] = mode_q != OFF && ctr_q < lvl_q;
    always_comb begin
      hit    = i_wr && i_addr == AW'(i);
      ramp   = frame_end && (mode_q == SAW || mode_q == BREATHE);
      take   = ramp && fc_q >= ivl_q;
      up     = lvl_q + PWM_BITS'(1);
      dn     = lvl_q - PWM_BITS'(1);
      // breathe turns around at both ends instead of wrapping
      stp    = mode_q == SAW ? up : dir_q == UP ? (lvl_q == MAX ? dn : up) : dn;
      sdir   = mode_q == SAW ? dir_q
             : dir_q == UP ? ((lvl_q == MAX || up == MAX) ? DOWN : UP)
             : (dn == '0 ? UP : DOWN);
      mode_d = hit ? mode_e'(i_data[1:0]) : mode_q;
      lvl_d  = hit ? i_data[PWM_BITS+7:8] : take ? stp : lvl_q;
      ivl_d  = hit ? i_data[31:16] : ivl_q;
      fc_d   = (hit || take) ? '0 : ramp ? fc_q + 16'(1) : fc_q;
      dir_d  = hit ? UP : take ? sdir : dir_q;
    end
    always_ff @(posedge i_clk)
      if (!i_reset_n) begin
        mode_q <= OFF;
        dir_q  <= UP;
        lvl_q  <= '0;
        ivl_q  <= '0;
        fc_q   <= '0;
      end else begin
        mode_q <= mode_d;
        dir_q  <= dir_d;
        lvl_q  <= lvl_d;
        ivl_q  <= ivl_d;
        fc_q   <= fc_d;
      end
  end
endmodule

// File: tb/tb_led_dimmer_array.sv
// tb_led_dimmer_array: directed checks of PWM duty, ramp modes, write rules and reset
module tb_led_dimmer_array;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] data = '0;
  logic [2:0]  led;
  logic        frame;
  int checks = 0, errors = 0;
  int cnt [3], rises [3], first [3];

  led_dimmer_array #(.NLED(3), .PWM_BITS(8), .AW(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr(wr), .i_addr(addr),
    .i_data(data), .o_led(led), .o_frame(frame)
  );

  always #5 clk = ~clk;

  task automatic wr_ch(input int ch, input logic [1:0] m, input logic [7:0] l, input logic [15:0] iv);
    wr = 1'b1; addr = 2'(ch); data = {iv, l, 6'h3f, m};
    @(negedge clk);
    wr = 1'b0; data = '0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin checks++; errors++; $display("FAIL wait_frame: no o_frame within %0d clocks", n); end
  endtask

  task automatic wr_at_end(input int ch, input logic [1:0] m, input logic [7:0] l, input logic [15:0] iv);
    wait_frame();
    repeat (255) @(negedge clk);
    wr_ch(ch, m, l, iv);
  endtask

  task automatic measure();
    logic [2:0] prev;
    prev = led;
    for (int c = 0; c < 3; c++) begin cnt[c] = 0; rises[c] = 0; first[c] = -1; end
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (led[c]) begin cnt[c]++; if (first[c] < 0) first[c] = k; end
        if (led[c] && !prev[c]) rises[c]++;
      end
      prev = led;
    end
    checks++;
    if (frame !== 1'b1) begin errors++; $display("FAIL frame_period: o_frame=%b expected 1", frame); end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s: got %0d expected %0d", name, got, exp); end
  endtask

  task automatic test_reset();
    int bad = 0, nf = 0, firstf = -1, lastf = -1, badgap = 0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 3'b000) begin errors++; $display("FAIL reset_led: got %b expected 000", led); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame); end
    rst_n = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      if (led !== 3'b000) bad++;
      if (frame) begin
        if (firstf < 0) firstf = k;
        if (lastf >= 0 && k - lastf != 256) badgap++;
        lastf = k; nf++;
      end
    end
    chk("idle_led_low", bad, 0);
    chk("idle_frame_count", nf, 4);
    chk("idle_first_frame", firstf, 256);
    chk("idle_frame_gap", badgap, 0);
  endtask

  task automatic test_fixed();
    wr_ch(1, 2'd1, 8'd64, 16'd0);
    wait_frame();
    measure();
    chk("fixed64_count", cnt[1], 64);
    chk("fixed64_runs", rises[1], 1);
    chk("fixed64_start", first[1], 1);
    chk("off_ch0", cnt[0], 0);
    wr_ch(1, 2'd1, 8'd0, 16'd0);
    wait_frame();
    measure();
    chk("fixed0_count", cnt[1], 0);
    wr_ch(1, 2'd1, 8'd255, 16'd0);
    wait_frame();
    measure();
    chk("fixed255_count", cnt[1], 255);
    chk("fixed255_runs", rises[1], 1);
  endtask

  task automatic test_saw();
    int exp5 [5] = '{253, 254, 255, 0, 1};
    int exp6 [6] = '{10, 10, 10, 11, 11, 11};
    wr_at_end(0, 2'd2, 8'd253, 16'd0);
    for (int f = 0; f < 5; f++) begin measure(); chk($sformatf("saw_i0_f%0d", f), cnt[0], exp5[f]); end
    wr_at_end(0, 2'd2, 8'd10, 16'd2);
    for (int f = 0; f < 6; f++) begin measure(); chk($sformatf("saw_i2_f%0d", f), cnt[0], exp6[f]); end
  endtask

  task automatic test_write_rules();
    wr_ch(0, 2'd2, 8'd50, 16'd0);
    wr_at_end(0, 2'd2, 8'd100, 16'd0);
    measure();
    chk("collide_write_wins", cnt[0], 100);
    measure();
    chk("collide_then_step", cnt[0], 101);
    wr_ch(0, 2'd1, 8'd30, 16'd0);
    wr_ch(1, 2'd1, 8'd120, 16'd0);
    wr_ch(2, 2'd1, 8'd90, 16'd0);
    wr_at_end(3, 2'd1, 8'd200, 16'd0);
    measure();
    chk("badaddr_ch0", cnt[0], 30);
    chk("badaddr_ch1", cnt[1], 120);
    chk("badaddr_ch2", cnt[2], 90);
  endtask

  task automatic test_breathe();
    int exp = 254, dn = 0;
    wr_at_end(2, 2'd3, 8'd254, 16'd0);
    for (int f = 0; f < 259; f++) begin
      measure();
      chk($sformatf("breathe_f%0d", f), cnt[2], exp);
      if (dn == 0) begin exp++; if (exp == 255) dn = 1; end
      else begin exp--; if (exp == 0) dn = 0; end
    end
  endtask

  task automatic test_midreset();
    int n = 0;
    wr_at_end(2, 2'd3, 8'd100, 16'd0);
    measure();
    chk("pre_reset_level", cnt[2], 100);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    wr = 1'b1; addr = 2'd1; data = {16'd0, 8'd200, 8'd1};
    @(negedge clk);
    wr = 1'b0; data = '0;
    checks++; if (led !== 3'b000) begin errors++; $display("FAIL midreset_led: got %b expected 000", led); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL midreset_frame: got %b expected 0", frame); end
    rst_n = 1'b1;
    while (!frame && n < 300) begin @(negedge clk); n++; end
    chk("midreset_ctr_restart", n, 256);
    measure();
    chk("midreset_off_ch0", cnt[0], 0);
    chk("midreset_off_ch1", cnt[1], 0);
    chk("midreset_off_ch2", cnt[2], 0);
    wr_ch(2, 2'd1, 8'd77, 16'd0);
    wait_frame();
    measure();
    chk("restart_fixed", cnt[2], 77);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_saw();
    test_write_rules();
    test_breathe();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
